// File: rtl/stopwatch_ctrl_pkg.sv
// stopwatch_ctrl_pkg: shared state encoding and BCD limit for the stopwatch and display driver
package stopwatch_ctrl_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_FULL  = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// bcd_digit: modulo-10 counter with enable and combinational carry out
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = en && q == BCD_MAX;
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (en) q <= q == BCD_MAX ? '0 : q + 4'd1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear FSM, 100 Hz prescaler and saturating 00.00-99.99 BCD cascade
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_clear,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       ovf
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  state_t state, state_nx;
  logic [PW-1:0] pre;
  logic cnt, tick, clr, all9;
  logic [2:0] c;
  logic unused_carry;
  // A pause pulse freezes the prescaler on that same edge, so its tick is dropped
  always_comb begin
    cnt = state == S_RUN && !btn_start;
    tick = cnt && pre == LAST;
    clr = btn_clear && state != S_RUN;
    all9 = {d3, d2, d1, d0} == {4{BCD_MAX}};
    state_nx = clr ? S_IDLE :
               state == S_RUN ? (btn_start ? S_PAUSE : tick && all9 ? S_FULL : S_RUN) :
               btn_start && state != S_FULL ? S_RUN : state;
  end
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset || clr) pre <= '0;
    else if (cnt) pre <= tick ? '0 : pre + 1'b1;
  assign running = state == S_RUN;
  assign ovf = state == S_FULL;
  bcd_digit u_d0 (.clk, .reset, .en(tick && !all9), .clr, .q(d0), .carry(c[0]));
  bcd_digit u_d1 (.clk, .reset, .en(c[0]), .clr, .q(d1), .carry(c[1]));
  bcd_digit u_d2 (.clk, .reset, .en(c[1]), .clr, .q(d2), .carry(c[2]));
  bcd_digit u_d3 (.clk, .reset, .en(c[2]), .clr, .q(d3), .carry(unused_carry));
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed stimulus with a per-cycle behavioural model of the stopwatch
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, FULL = 3;
  logic clk = 0, reset = 1, btn_start = 0, btn_clear = 0;
  logic [3:0] d0, d1, d2, d3;
  logic running, ovf;
  int tests = 0, fails = 0;
  bit chk = 0;
  int mt = 0, ms = IDLE, mp = 0;
  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_clear(btn_clear),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .running(running), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got digits %h run %b ovf %b, expected digits %h run %b ovf %b",
               nm, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
    end
  endtask
  function automatic logic [17:0] obs();
    return {d3, d2, d1, d0, running, ovf};
  endfunction
  function automatic logic [17:0] lit(input logic [15:0] bcd, input logic r, input logic o);
    return {bcd, r, o};
  endfunction
  // Model: time as an integer count of hundredths, prescaler as a cycle counter
  always @(posedge clk) begin
    if (reset) begin
      mt = 0; ms = IDLE; mp = 0;
    end else if (ms == RUN) begin
      if (btn_start) ms = PAUSE;
      else if (mp == TD - 1) begin
        mp = 0;
        if (mt == 9999) ms = FULL;
        else mt++;
      end else mp++;
    end else if (btn_clear) begin
      ms = IDLE; mt = 0; mp = 0;
    end else if (btn_start && ms != FULL) ms = RUN;
  end
  always @(negedge clk)
    if (chk)
      check("model", obs(), {4'(mt / 1000), 4'((mt / 100) % 10), 4'((mt / 10) % 10), 4'(mt % 10),
                             ms == RUN, ms == FULL});
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic s, input logic c);
    btn_start = s; btn_clear = c;
    @(negedge clk);
    btn_start = 0; btn_clear = 0;
  endtask
  initial begin
    cyc(2);
    reset = 0; chk = 1;
    check("reset_state", obs(), lit(16'h0000, 0, 0));
    pulse(1, 0);
    cyc(1308);
    check("run_to_0327", obs(), lit(16'h0327, 1, 0));
    reset = 1; btn_start = 1;
    @(negedge clk);
    reset = 0; btn_start = 0;
    check("reset_midrun", obs(), lit(16'h0000, 0, 0));
    cyc(5);
    check("start_with_reset_ignored", obs(), lit(16'h0000, 0, 0));
    pulse(1, 0);
    check("start_running", obs(), lit(16'h0000, 1, 0));
    cyc(3);
    check("before_first_tick", obs(), lit(16'h0000, 1, 0));
    cyc(1);
    check("first_tick", obs(), lit(16'h0001, 1, 0));
    cyc(4);
    check("second_tick", obs(), lit(16'h0002, 1, 0));
    cyc(32);
    check("d0_wrap_carry", obs(), lit(16'h0010, 1, 0));
    cyc(2);
    pulse(1, 0);
    check("pause", obs(), lit(16'h0010, 0, 0));
    cyc(20);
    check("pause_hold", obs(), lit(16'h0010, 0, 0));
    pulse(1, 0);
    check("resume", obs(), lit(16'h0010, 1, 0));
    cyc(1);
    check("resume_plus1", obs(), lit(16'h0010, 1, 0));
    cyc(1);
    check("resume_partial_kept", obs(), lit(16'h0011, 1, 0));
    pulse(0, 1);
    check("clear_in_run_ignored", obs(), lit(16'h0011, 1, 0));
    pulse(1, 1);
    check("start_clear_in_run", obs(), lit(16'h0011, 0, 0));
    reset = 1;
    cyc(1);
    reset = 0;
    pulse(1, 0);
    cyc(20);
    pulse(1, 0);
    check("pause_at_0005", obs(), lit(16'h0005, 0, 0));
    pulse(1, 1);
    check("start_clear_in_pause", obs(), lit(16'h0000, 0, 0));
    pulse(1, 0);
    cyc(999 * TD);
    check("at_0999", obs(), lit(16'h0999, 1, 0));
    cyc(TD - 1);
    check("hold_0999", obs(), lit(16'h0999, 1, 0));
    cyc(1);
    check("ripple_1000", obs(), lit(16'h1000, 1, 0));
    cyc(8999 * TD);
    check("at_9999", obs(), lit(16'h9999, 1, 0));
    cyc(TD - 1);
    check("hold_9999", obs(), lit(16'h9999, 1, 0));
    cyc(1);
    check("saturate", obs(), lit(16'h9999, 0, 1));
    pulse(1, 0);
    check("start_in_full_ignored", obs(), lit(16'h9999, 0, 1));
    cyc(10);
    check("full_hold", obs(), lit(16'h9999, 0, 1));
    pulse(0, 1);
    check("clear_from_full", obs(), lit(16'h0000, 0, 0));
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
